// File: rtl/pvr_texel_fetch.sv
// -----------------------------------------------------------------------------
// pvr_texel_fetch
//
// Texel fetch front end for the PVR 64-bit read cache. A texel request carries
// a VRAM byte address and a pixel format. The block turns it into a 64-bit word
// read, then picks the 16-, 8- or 4-bit texel out of the returned word and
// offers it on a valid/ready output. The last fetched word is kept together
// with its word address (the tag). A request that falls in that same word is
// answered from the stored copy and issues no memory read.
//
// A read that gets no answer within TIMEOUT wait cycles is aborted. The block
// then returns a zero texel flagged with texel_err.
//
// Ports
//   clock, reset_n     system clock, asynchronous active-low reset
//   req_valid/ready    texel request handshake (ready only while idle)
//   req_addr[31:0]     VRAM byte address of the texel
//   req_fmt[1:0]       0=16bpp, 1=8bpp, 2=4bpp, 3=reserved (handled as 16bpp)
//   req_nib            4bpp nibble select (0=low, 1=high)
//   inval              one-cycle pulse: VRAM was written, drop the stored word
//   mem_addr[28:0]     word address presented to the cache
//   mem_rd             one-cycle read strobe to the cache
//   mem_valid          one-cycle read-data strobe from the cache
//   mem_readdata[63:0] word returned by the cache
//   texel_valid/ready  texel output handshake
//   texel_data[15:0]   extracted texel, zero-extended
//   texel_err          marks a timed-out request (texel_data is then 0)
// -----------------------------------------------------------------------------
module pvr_texel_fetch #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_fmt,
    input  logic        req_nib,
    input  logic        inval,
    output logic [28:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_valid,
    input  logic [63:0] mem_readdata,
    output logic        texel_valid,
    input  logic        texel_ready,
    output logic [15:0] texel_data,
    output logic        texel_err
);

    // RD is the single cycle in which mem_rd is high. WAIT follows it.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state;
    state_t      state_next;

    // Stored word and its tag. tag_valid alone qualifies them, so the word and
    // tag registers themselves need no reset.
    logic [63:0] word;
    logic [28:0] tag;
    logic        tag_valid;

    // Request fields held across the memory round trip.
    logic [2:0]  lane;
    logic [1:0]  fmt;
    logic        nib;

    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_inc;
    logic        inval_seen;

    logic        accept;
    logic        hit;
    logic        resp;
    logic        expire;

    // Pick the texel from a 64-bit word. Lane 0 is the least significant byte.
    function automatic logic [15:0] extract_texel(
        input logic [63:0] w,
        input logic [2:0]  b,
        input logic [1:0]  f,
        input logic        n
    );
        logic [7:0] byte_val;
        byte_val = w[{b, 3'b000} +: 8];
        case (f)
            2'd1:    extract_texel = {8'd0, byte_val};
            2'd2:    extract_texel = {12'd0, (n ? byte_val[7:4] : byte_val[3:0])};
            default: extract_texel = w[{b[2:1], 4'b0000} +: 16];
        endcase
    endfunction

    assign accept       = (state == S_IDLE) & req_valid;
    // An inval in the accept cycle makes the stored word stale, so the
    // request counts as a miss.
    assign hit          = tag_valid & (req_addr[31:3] == tag) & ~inval;
    assign resp         = (state == S_WAIT) & mem_valid;
    assign wait_cnt_inc = wait_cnt + 8'd1;
    assign expire       = (state == S_WAIT) & ~mem_valid & (wait_cnt_inc == TIMEOUT_CNT);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_next = hit ? S_OUT : S_RD;
                end
            end
            S_RD: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem_valid || expire) begin
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (texel_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready   = (state == S_IDLE);
        mem_rd      = (state == S_RD);
        texel_valid = (state == S_OUT);
    end

    // Control and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr   <= '0;
            tag_valid  <= 1'b0;
            wait_cnt   <= '0;
            inval_seen <= 1'b0;
            texel_data <= '0;
            texel_err  <= 1'b0;
        end else begin
            if (accept) begin
                mem_addr   <= req_addr[31:3];
                wait_cnt   <= '0;
                inval_seen <= 1'b0;
            end

            // Remember an inval seen while the read is outstanding. The word
            // it returns may predate that VRAM write.
            if (((state == S_RD) || (state == S_WAIT)) && inval) begin
                inval_seen <= 1'b1;
            end

            if ((state == S_WAIT) && !mem_valid) begin
                wait_cnt <= wait_cnt_inc;
            end

            if (accept && hit) begin
                texel_data <= extract_texel(word, req_addr[2:0], req_fmt, req_nib);
                texel_err  <= 1'b0;
            end

            if (resp) begin
                texel_data <= extract_texel(mem_readdata, lane, fmt, nib);
                texel_err  <= 1'b0;
                tag_valid  <= ~inval_seen;
            end

            if (expire) begin
                texel_data <= '0;
                texel_err  <= 1'b1;
                tag_valid  <= 1'b0;
            end

            if ((state == S_OUT) && texel_ready) begin
                texel_err <= 1'b0;
            end

            // An inval always wins over any tag update in the same cycle.
            if (inval) begin
                tag_valid <= 1'b0;
            end
        end
    end

    // Datapath registers, qualified by the control state above
    always_ff @(posedge clock) begin
        if (accept) begin
            lane <= req_addr[2:0];
            fmt  <= req_fmt;
            nib  <= req_nib;
        end
        if (resp) begin
            word <= mem_readdata;
            tag  <= mem_addr;
        end
    end

endmodule

// File: tb/tb_pvr_texel_fetch.sv
// -----------------------------------------------------------------------------
// tb_pvr_texel_fetch
//
// Directed bench for pvr_texel_fetch. A transaction-level model tracks the
// stored word and tag. For each request it predicts hit or miss, the cycle of
// the read strobe, the cycle texel_valid rises and the texel value. One
// negedge process compares the DUT against those predictions on every cycle.
// Each transaction also carries a hand-computed texel literal.
// -----------------------------------------------------------------------------
module tb_pvr_texel_fetch;

    localparam int TO   = 4;
    localparam int SENT = 32'h7fff_ffff;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_fmt = '0;
    logic        req_nib = 1'b0;
    logic        inval = 1'b0;
    logic [28:0] mem_addr;
    logic        mem_rd;
    logic        mem_valid = 1'b0;
    logic [63:0] mem_readdata = '0;
    logic        texel_valid;
    logic        texel_ready = 1'b0;
    logic [15:0] texel_data;
    logic        texel_err;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Expectations maintained by the stimulus
    bit          chk_en = 1'b0;
    bit          busy = 1'b0;
    int          exp_rd_cyc = SENT;
    int          exp_tv_cyc = SENT;
    logic [28:0] exp_addr = '0;
    logic [16:0] exp_out = '0;

    // Model of the stored word
    logic [63:0] m_word = '0;
    logic [28:0] m_tag = '0;
    bit          m_tag_valid = 1'b0;

    pvr_texel_fetch #(.TIMEOUT(TO)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_fmt      (req_fmt),
        .req_nib      (req_nib),
        .inval        (inval),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_valid    (mem_valid),
        .mem_readdata (mem_readdata),
        .texel_valid  (texel_valid),
        .texel_ready  (texel_ready),
        .texel_data   (texel_data),
        .texel_err    (texel_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Texel as the format rules define it, computed with shifts on the word
    function automatic logic [15:0] model_texel(input logic [63:0] w, input logic [31:0] a,
                                                input logic [1:0] f, input bit n);
        int b;
        logic [63:0] byte_v;
        b = int'(a[2:0]);
        byte_v = (w >> (8 * b)) & 64'hFF;
        case (f)
            2'd1:    return byte_v[15:0];
            2'd2:    return n ? 16'(byte_v >> 4) : 16'(byte_v & 64'hF);
            default: return 16'((w >> (16 * (b / 2))) & 64'hFFFF);
        endcase
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            check("req_ready", 64'(req_ready), 64'(!busy));
            check("mem_rd", 64'(mem_rd), 64'(cyc == exp_rd_cyc));
            if (cyc == exp_rd_cyc) check("mem_addr", 64'(mem_addr), 64'(exp_addr));
            check("texel_valid", 64'(texel_valid), 64'(cyc >= exp_tv_cyc));
            if (cyc >= exp_tv_cyc) check("texel_out", 64'({texel_err, texel_data}), 64'(exp_out));
        end
    end

    // One request from accept to texel handshake. The bench is aligned just
    // after a rising edge on entry and on exit.
    task automatic do_req(input logic [31:0] addr, input logic [1:0] fmt, input bit nib,
                          input bit inv_acc, input bit respond, input int dly,
                          input logic [63:0] rword, input bit inv_wait, input int rdy_dly,
                          input logic [16:0] lit, input string name);
        bit hit;
        int a;
        int n;
        hit = m_tag_valid && (m_tag == addr[31:3]) && !inv_acc;
        req_valid = 1'b1;
        req_addr  = addr;
        req_fmt   = fmt;
        req_nib   = nib;
        inval     = inv_acc;
        @(posedge clock); #1;
        a = cyc;
        req_valid = 1'b0;
        inval     = 1'b0;
        if (inv_acc) m_tag_valid = 1'b0;
        busy = 1'b1;
        if (hit) begin
            exp_out    = {1'b0, model_texel(m_word, addr, fmt, nib)};
            exp_tv_cyc = a;
        end else begin
            exp_rd_cyc = a;
            exp_addr   = addr[31:3];
            if (respond) begin
                exp_out    = {1'b0, model_texel(rword, addr, fmt, nib)};
                exp_tv_cyc = a + dly + 1;
            end else begin
                exp_out    = 17'h10000;
                exp_tv_cyc = a + TO + 1;
            end
        end
        if (!hit && respond) begin
            for (int i = 0; i < dly; i++) begin
                @(posedge clock); #1;
                inval = inv_wait && (i == 0);
            end
            inval = 1'b0;
            mem_valid = 1'b1;
            mem_readdata = rword;
            @(posedge clock); #1;
            mem_valid = 1'b0;
            m_word = rword;
            m_tag = addr[31:3];
            m_tag_valid = !inv_wait;
        end else if (!hit) begin
            m_tag_valid = 1'b0;
        end
        n = 0;
        while (cyc < exp_tv_cyc && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        @(negedge clock);
        check(name, 64'({texel_valid, texel_err, texel_data}), 64'({1'b1, lit}));
        repeat (rdy_dly) @(negedge clock);
        texel_ready = 1'b1;
        @(posedge clock); #1;
        texel_ready = 1'b0;
        busy = 1'b0;
        exp_tv_cyc = SENT;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset mem_rd", 64'(mem_rd), 64'd0);
        check("reset mem_addr", 64'(mem_addr), 64'd0);
        check("reset texel_valid", 64'(texel_valid), 64'd0);
        check("reset texel_data", 64'(texel_data), 64'd0);
        check("reset texel_err", 64'(texel_err), 64'd0);
        reset_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clock); #1;

        // Cold miss, then hits into the same word
        do_req(32'h100, 2'd0, 0, 0, 1, 3, 64'h1111_2222_3333_4444, 0, 0, 17'h04444, "cold miss");
        do_req(32'h106, 2'd0, 0, 0, 1, 3, 64'h0, 0, 0, 17'h01111, "hit 16bpp");
        do_req(32'h103, 2'd1, 0, 0, 1, 3, 64'h0, 0, 0, 17'h00033, "hit 8bpp");

        // 4bpp nibbles, other lanes, reserved format, backpressure
        do_req(32'h200, 2'd2, 1, 0, 1, 2, 64'h0123_4567_89AB_CDA5, 0, 0, 17'h0000A, "4bpp high");
        do_req(32'h200, 2'd2, 0, 0, 1, 2, 64'h0, 0, 0, 17'h00005, "4bpp low");
        do_req(32'h205, 2'd1, 0, 0, 1, 2, 64'h0, 0, 0, 17'h00045, "8bpp lane5");
        do_req(32'h202, 2'd3, 0, 0, 1, 2, 64'h0, 0, 0, 17'h089AB, "reserved fmt");
        do_req(32'h204, 2'd0, 0, 0, 1, 2, 64'h0, 0, 10, 17'h04567, "backpressure");

        // Timeout, late response dropped, refetch of the same word
        do_req(32'h300, 2'd0, 0, 0, 0, 0, 64'h0, 0, 0, 17'h10000, "timeout");
        mem_valid = 1'b1;
        mem_readdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clock); #1;
        mem_valid = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        do_req(32'h300, 2'd0, 0, 0, 1, 2, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 17'h0F00D, "refetch after timeout");

        // Invalidate at accept and during the wait
        do_req(32'h302, 2'd0, 0, 1, 1, 1, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 17'h0CAFE, "inval at accept");
        do_req(32'h308, 2'd1, 0, 0, 1, 3, 64'h0807_0605_0403_0201, 1, 0, 17'h00001, "inval in wait");
        do_req(32'h309, 2'd1, 0, 0, 1, 2, 64'h0807_0605_0403_0201, 0, 0, 17'h00002, "miss after wait inval");
        do_req(32'h30A, 2'd1, 0, 0, 1, 2, 64'h0, 0, 1, 17'h00003, "hit after refetch");

        // Reset while a read is outstanding; the late response must be dropped
        req_valid = 1'b1;
        req_addr  = 32'h400;
        req_fmt   = 2'd0;
        @(posedge clock); #1;
        req_valid  = 1'b0;
        busy       = 1'b1;
        exp_rd_cyc = cyc;
        exp_addr   = 29'h80;
        repeat (2) begin @(posedge clock); #1; end
        reset_n = 1'b0;
        busy = 1'b0;
        m_tag_valid = 1'b0;
        #2;
        check("midreset mem_addr", 64'(mem_addr), 64'd0);
        check("midreset req_ready", 64'(req_ready), 64'd1);
        @(posedge clock); #1;
        reset_n = 1'b1;
        mem_valid = 1'b1;
        mem_readdata = 64'h1234_5678_9ABC_DEF0;
        @(posedge clock); #1;
        mem_valid = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        do_req(32'h30A, 2'd1, 0, 0, 1, 2, 64'h0807_0605_0403_0201, 0, 0, 17'h00003, "miss after reset");

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
